// File: rtl/ramp_dac_gen.sv
// Reference-ramp generator for the single-slope ADC: settle/discharge, stepped ramp code,
// and a first-order delta-sigma bitstream of that code for the external RC filter.
module ramp_dac_gen #(
  parameter int CODE_BITS    = 10,
  parameter int STEP_CYCLES  = 4,
  parameter int DISCH_CYCLES = 64,
  parameter int RAMP_MAX     = 1023,
  parameter bit CONTINUOUS   = 1'b0
) (
  input  logic                 clk_in,
  input  logic                 user_reset,
  input  logic                 enable,
  input  logic                 start,
  output logic                 ramp_pdm,
  output logic                 discharge,
  output logic [CODE_BITS-1:0] ramp_code,
  output logic                 ramp_sync,
  output logic                 busy,
  output logic                 done
);

  localparam int CNT_MAX = (DISCH_CYCLES > STEP_CYCLES) ? DISCH_CYCLES : STEP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0]     DISCH_LAST = CNT_W'(DISCH_CYCLES - 1);
  localparam logic [CNT_W-1:0]     STEP_LAST  = CNT_W'(STEP_CYCLES - 1);
  localparam logic [CODE_BITS-1:0] CODE_LAST  = CODE_BITS'(RAMP_MAX);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_RAMP   = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CODE_BITS-1:0] code_q, code_d;
  logic [CODE_BITS:0]   acc_q, acc_d;
  logic                 pdm_q, pdm_d;
  logic                 discharge_q, discharge_d;
  logic                 sync_q, sync_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [CODE_BITS-1:0] acc_base_s;
  logic [CODE_BITS:0]   sum_s;

  always_ff @(posedge clk_in) begin
    if (user_reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      code_q      <= '0;
      acc_q       <= '0;
      pdm_q       <= 1'b0;
      discharge_q <= 1'b1;
      sync_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      code_q      <= code_d;
      acc_q       <= acc_d;
      pdm_q       <= pdm_d;
      discharge_q <= discharge_d;
      sync_q      <= sync_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Completion is tested before abort so a ramp finishing as enable drops still reports done.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d  = '0;
        code_d = '0;
        if (start && enable) state_d = S_SETTLE;
        else                 state_d = S_IDLE;
      end
      S_SETTLE: begin
        code_d = '0;
        if (!enable) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DISCH_LAST) begin
          state_d = S_RAMP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RAMP: begin
        if ((cnt_q == STEP_LAST) && (code_q == CODE_LAST)) begin
          done_d  = 1'b1;
          cnt_d   = '0;
          code_d  = '0;
          state_d = (CONTINUOUS && enable) ? S_SETTLE : S_IDLE;
        end else if (!enable) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          code_d  = '0;
        end else if (cnt_q == STEP_LAST) begin
          cnt_d  = '0;
          code_d = code_q + CODE_BITS'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        code_d  = '0;
      end
    endcase
  end

  // Modulator integrates the code that will be on ramp_code next cycle, so pdm and code align.
  always_comb begin
    acc_base_s  = (state_q == S_RAMP) ? acc_q[CODE_BITS-1:0] : '0;
    sum_s       = {1'b0, acc_base_s} + {1'b0, code_d};
    discharge_d = (state_d != S_RAMP);
    busy_d      = (state_d != S_IDLE);
    sync_d      = (state_q != S_RAMP) && (state_d == S_RAMP);
    if (state_d == S_RAMP) begin
      acc_d = sum_s;
      pdm_d = sum_s[CODE_BITS];
    end else begin
      acc_d = '0;
      pdm_d = 1'b0;
    end
  end

  assign ramp_pdm  = pdm_q;
  assign discharge = discharge_q;
  assign ramp_code = code_q;
  assign ramp_sync = sync_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_ramp_dac_gen.sv
// Directed bench for ramp_dac_gen: one-shot instance and a continuous-mode instance
// sharing clock and reset, checked cycle by cycle against hand-derived timing.
module tb_ramp_dac_gen;

  localparam int CB = 4;

  logic          clk = 1'b0;
  logic          user_reset, enable, start, enable_c, start_c;
  logic          ramp_pdm, discharge, ramp_sync, busy, done;
  logic [CB-1:0] ramp_code;
  logic          ramp_pdm_c, discharge_c, ramp_sync_c, busy_c, done_c;
  logic [CB-1:0] ramp_code_c;

  int checks = 0;
  int errors = 0;

  ramp_dac_gen #(.CODE_BITS(CB), .STEP_CYCLES(2), .DISCH_CYCLES(3), .RAMP_MAX(15),
                 .CONTINUOUS(1'b0)) dut (
    .clk_in(clk), .user_reset(user_reset), .enable(enable), .start(start),
    .ramp_pdm(ramp_pdm), .discharge(discharge), .ramp_code(ramp_code),
    .ramp_sync(ramp_sync), .busy(busy), .done(done));

  ramp_dac_gen #(.CODE_BITS(CB), .STEP_CYCLES(2), .DISCH_CYCLES(3), .RAMP_MAX(15),
                 .CONTINUOUS(1'b1)) dut_c (
    .clk_in(clk), .user_reset(user_reset), .enable(enable_c), .start(start_c),
    .ramp_pdm(ramp_pdm_c), .discharge(discharge_c), .ramp_code(ramp_code_c),
    .ramp_sync(ramp_sync_c), .busy(busy_c), .done(done_c));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_disch"}, discharge, 1);
    chk({tag, "_pdm"},   ramp_pdm,  0);
    chk({tag, "_busy"},  busy,      0);
    chk({tag, "_code"},  ramp_code, 0);
    chk({tag, "_sync"},  ramp_sync, 0);
    chk({tag, "_done"},  done,      0);
  endtask

  // Start in cycle 0, then check cycles 1..37; pa/pb are cycles in which start is re-pulsed.
  task automatic full_ramp(input string tag, input int pa, input int pb);
    int ones;
    ones  = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 37; c++) begin
      chk($sformatf("%s_disch@%0d", tag, c), discharge, (c < 4 || c > 35) ? 1 : 0);
      chk($sformatf("%s_sync@%0d", tag, c), ramp_sync, (c == 4) ? 1 : 0);
      chk($sformatf("%s_code@%0d", tag, c), ramp_code, (c >= 4 && c <= 35) ? (c - 4) / 2 : 0);
      chk($sformatf("%s_done@%0d", tag, c), done, (c == 36) ? 1 : 0);
      if (c != 36) chk($sformatf("%s_busy@%0d", tag, c), busy, (c <= 35) ? 1 : 0);
      if (c < 4)   chk($sformatf("%s_pdm@%0d", tag, c), ramp_pdm, 0);
      if (c >= 4 && c <= 35 && ramp_pdm === 1'b1) ones++;
      start = (c == pa || c == pb);
      tick();
    end
    start = 1'b0;
    chk({tag, "_pdm_ones"}, ones, 15);
  endtask

  initial begin
    int p, r, macc, ones_c;
    user_reset = 1'b1;
    enable     = 1'b0;
    start      = 1'b0;
    enable_c   = 1'b0;
    start_c    = 1'b0;
    tick();
    tick();
    chk_idle("rst");
    chk("rst_c_disch", discharge_c, 1);
    chk("rst_c_busy",  busy_c,      0);
    user_reset = 1'b0;

    // Idle with enable high and no start.
    enable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk_idle($sformatf("s1_%0d", i));
    end

    full_ramp("s2", 0, 0);

    // Continuous mode: three back-to-back ramps, enable falls in the last cycle of ramp 3.
    enable_c = 1'b1;
    start_c  = 1'b1;
    tick();
    start_c = 1'b0;
    macc    = 0;
    ones_c  = 0;
    for (int c = 1; c <= 106; c++) begin
      chk($sformatf("s3_busy@%0d", c), busy_c, (c != 106) ? 1 : 0);
      if (c < 4) begin
        chk($sformatf("s3_disch@%0d", c), discharge_c, 1);
        chk($sformatf("s3_sync@%0d", c), ramp_sync_c, 0);
      end else begin
        p = (c - 4) % 35;
        r = (c - 4) / 35;
        if (p < 32) begin
          if (p == 0) begin
            macc   = 0;
            ones_c = 0;
          end
          macc = (macc % 16) + p / 2;
          if (macc >= 16) ones_c++;
          chk($sformatf("s3_disch@%0d", c), discharge_c, 0);
          chk($sformatf("s3_code@%0d", c), ramp_code_c, p / 2);
          chk($sformatf("s3_sync@%0d", c), ramp_sync_c, (p == 0) ? 1 : 0);
          chk($sformatf("s3_done@%0d", c), done_c, 0);
          chk($sformatf("s3_pdm@%0d", c), ramp_pdm_c, (macc >= 16) ? 1 : 0);
          if (p == 31) chk($sformatf("s3_ones_r%0d", r), ones_c, 15);
        end else begin
          chk($sformatf("s3_disch@%0d", c), discharge_c, 1);
          chk($sformatf("s3_done@%0d", c), done_c, (p == 32) ? 1 : 0);
          chk($sformatf("s3_sync@%0d", c), ramp_sync_c, 0);
        end
      end
      if (c == 105) enable_c = 1'b0;
      tick();
    end
    chk("s3_end_done",  done_c,      0);
    chk("s3_end_busy",  busy_c,      0);
    chk("s3_end_disch", discharge_c, 1);
    chk("s3_end_code",  ramp_code_c, 0);

    // Abort at code 7.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 17; i++) tick();
    chk("s4_code7", ramp_code, 7);
    enable = 1'b0;
    tick();
    chk_idle("s4_abort");
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk_idle("s4_start_no_en");
    enable = 1'b1;
    tick();

    full_ramp("s5", 2, 10);

    // Reset at code 10, then a fresh ramp.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 23; i++) tick();
    chk("s6_code10", ramp_code, 10);
    user_reset = 1'b1;
    tick();
    chk_idle("s6_rst");
    user_reset = 1'b0;
    tick();
    full_ramp("s6", 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
